// File: rtl/timer_scheduler.sv
// Round-robin scheduler sharing one down-counting interval timer among NUM_REQ requesters.
// Optional feature: define TIMER_ABORT_EN to add an abort input that cancels a running timeout.
module timer_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16,
  parameter int IDX_W   = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] load_flat,
`ifdef TIMER_ABORT_EN
  input  logic                     abort,
`endif
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [CNT_W-1:0]         count,
  output logic [IDX_W-1:0]         owner
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 busy_q, busy_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     last_q, last_d;

  logic [CNT_W-1:0]     load_arr [NUM_REQ];
  logic [IDX_W-1:0]     win;
  logic                 win_vld;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      load_arr[i] = load_flat[i*CNT_W +: CNT_W];
    end
  end

  // Scan from the farthest slot back toward last_q+1 so the nearest asserted request wins.
  always_comb begin
    logic [IDX_W-1:0] idx;
    idx     = '0;
    win     = '0;
    win_vld = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IDX_W'((int'(last_q) + k) % NUM_REQ);
      if (req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    busy_d  = busy_q;
    count_d = count_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d      = RUN;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          owner_d      = win;
          last_d       = win;
          count_d      = load_arr[win];
          busy_d       = 1'b1;
        end
      end
      RUN: begin
`ifdef TIMER_ABORT_EN
        if (abort) begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          count_d = '0;
        end else
`endif
        if (count_q == '0) begin
          state_d         = IDLE;
          done_d[owner_q] = 1'b1;
          grant_d         = '0;
          busy_d          = 1'b0;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      count_q <= count_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign count = count_q;
  assign owner = owner_q;

endmodule
